decode_stage_pipe: RTL and testbench

DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

---
 rtl/decode_stage_pipe_if.sv | 51 +++++
 rtl/decode_stage_pipe.sv | 170 +++++++++++++++++
 tb/tb_decode_stage_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_stage_pipe_if : decode-side, writeback and execute-side signal bundle
// rev 1.0
// ---------------------------------------------------------------------------
interface decode_stage_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CTRLW = 16
);
  logic [31:0]       instr_d;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_plus4_d;
  logic              valid_d;
  logic [CTRLW-1:0]  ctrl_d;
  logic              load_d;
  logic              regwrite_w;
  logic [4:0]        rd_w;
  logic [XLEN-1:0]   result_w;
  logic              flush_e;
  logic              stall_ext;

  logic              stall_d;
  logic              valid_e;
  logic              load_e;
  logic [CTRLW-1:0]  ctrl_e;
  logic [XLEN-1:0]   rd1_e;
  logic [XLEN-1:0]   rd2_e;
  logic [XLEN-1:0]   imm_e;
  logic [4:0]        rs1_e;
  logic [4:0]        rs2_e;
  logic [4:0]        rd_e;
  logic [XLEN-1:0]   pc_e;
  logic [XLEN-1:0]   pc_plus4_e;
  logic [31:0]       instr_e;
  logic [15:0]       bubble_cnt;

  modport master (
    output instr_d, pc_d, pc_plus4_d, valid_d, ctrl_d, load_d,
    output regwrite_w, rd_w, result_w, flush_e, stall_ext,
    input  stall_d, valid_e, load_e, ctrl_e, rd1_e, rd2_e, imm_e,
    input  rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e, instr_e, bubble_cnt
  );

  modport slave (
    input  instr_d, pc_d, pc_plus4_d, valid_d, ctrl_d, load_d,
    input  regwrite_w, rd_w, result_w, flush_e, stall_ext,
    output stall_d, valid_e, load_e, ctrl_e, rd1_e, rd2_e, imm_e,
    output rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e, instr_e, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_stage_pipe : register file, immediate decode, load-use hazard and D->E pipe register
// rev 1.0
// ---------------------------------------------------------------------------
module decode_stage_pipe #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CTRLW = 16
) (
  input  logic                clk,
  input  logic                rst,
  decode_stage_pipe_if.slave  bus
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0]  r_regs [NREG];

  logic [31:0]      w_instr;
  logic [6:0]       w_opcode;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [IDX_W-1:0] w_rs1_idx;
  logic [IDX_W-1:0] w_rs2_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_en;
  logic [XLEN-1:0]  w_rd1;
  logic [XLEN-1:0]  w_rd2;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  logic             w_hazard;

  logic             r_valid_e;
  logic             r_load_e;
  logic [CTRLW-1:0] r_ctrl_e;
  logic [XLEN-1:0]  r_rd1_e;
  logic [XLEN-1:0]  r_rd2_e;
  logic [XLEN-1:0]  r_imm_e;
  logic [4:0]       r_rs1_e;
  logic [4:0]       r_rs2_e;
  logic [4:0]       r_rd_e;
  logic [XLEN-1:0]  r_pc_e;
  logic [XLEN-1:0]  r_pc_plus4_e;
  logic [31:0]      r_instr_e;
  logic [15:0]      r_bubble_cnt;

  assign w_instr   = bus.instr_d;
  assign w_opcode  = w_instr[6:0];
  assign w_rs1     = w_instr[19:15];
  assign w_rs2     = w_instr[24:20];
  assign w_rs1_idx = w_rs1[IDX_W-1:0];
  assign w_rs2_idx = w_rs2[IDX_W-1:0];
  assign w_wr_idx  = bus.rd_w[IDX_W-1:0];
  assign w_wr_en   = bus.regwrite_w && (w_wr_idx != '0);

  // Writes are never gated by pipeline control; x0 writes are simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_idx] <= bus.result_w;
    end
  end

  // Write-through: a same-cycle writeback to the read index wins over the array.
  always_comb begin
    w_rd1 = r_regs[w_rs1_idx];
    if (w_rs1_idx == '0)
      w_rd1 = '0;
    else if (w_wr_en && (w_wr_idx == w_rs1_idx))
      w_rd1 = bus.result_w;
  end

  always_comb begin
    w_rd2 = r_regs[w_rs2_idx];
    if (w_rs2_idx == '0)
      w_rd2 = '0;
    else if (w_wr_en && (w_wr_idx == w_rs2_idx))
      w_rd2 = bus.result_w;
  end

  always_comb begin
    w_imm32 = '0;
    case (w_opcode)
      7'b0010011, 7'b0000011, 7'b1100111:
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      7'b0100011:
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      7'b1100011:
        w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                   w_instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        w_imm32 = {w_instr[31:12], 12'b0};
      7'b1101111:
        w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                   w_instr[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // Conservative: any matching source field counts, whether or not it is used.
  assign w_hazard = bus.valid_d & r_valid_e & r_load_e & (r_rd_e != 5'd0) &
                    ((r_rd_e == w_rs1) | (r_rd_e == w_rs2));

  assign bus.stall_d = (w_hazard | bus.stall_ext) & ~bus.flush_e;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_e    <= 1'b0;
      r_load_e     <= 1'b0;
      r_ctrl_e     <= '0;
      r_rd1_e      <= '0;
      r_rd2_e      <= '0;
      r_imm_e      <= '0;
      r_rs1_e      <= '0;
      r_rs2_e      <= '0;
      r_rd_e       <= '0;
      r_pc_e       <= '0;
      r_pc_plus4_e <= '0;
      r_instr_e    <= '0;
    end else if (!bus.flush_e && bus.stall_ext) begin
      r_valid_e    <= r_valid_e;
    end else if (!bus.flush_e && w_hazard) begin
      r_valid_e    <= 1'b0;
      r_load_e     <= 1'b0;
      r_ctrl_e     <= '0;
    end else begin
      // Flush still loads the data fields; only the qualifiers are killed.
      r_valid_e    <= bus.valid_d & ~bus.flush_e;
      r_load_e     <= bus.valid_d & bus.load_d & ~bus.flush_e;
      r_ctrl_e     <= (bus.valid_d && !bus.flush_e) ? bus.ctrl_d : '0;
      r_rd1_e      <= w_rd1;
      r_rd2_e      <= w_rd2;
      r_imm_e      <= w_imm;
      r_rs1_e      <= w_rs1;
      r_rs2_e      <= w_rs2;
      r_rd_e       <= w_instr[11:7];
      r_pc_e       <= bus.pc_d;
      r_pc_plus4_e <= bus.pc_plus4_d;
      r_instr_e    <= w_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_bubble_cnt <= '0;
    else if (!bus.flush_e && !bus.stall_ext && w_hazard && (r_bubble_cnt != 16'hFFFF))
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign bus.valid_e    = r_valid_e;
  assign bus.load_e     = r_load_e;
  assign bus.ctrl_e     = r_ctrl_e;
  assign bus.rd1_e      = r_rd1_e;
  assign bus.rd2_e      = r_rd2_e;
  assign bus.imm_e      = r_imm_e;
  assign bus.rs1_e      = r_rs1_e;
  assign bus.rs2_e      = r_rs2_e;
  assign bus.rd_e       = r_rd_e;
  assign bus.pc_e       = r_pc_e;
  assign bus.pc_plus4_e = r_pc_plus4_e;
  assign bus.instr_e    = r_instr_e;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_decode_stage_pipe : directed scoreboard bench for decode_stage_pipe
// rev 1.0
// ---------------------------------------------------------------------------
module tb_decode_stage_pipe;

  localparam int M_CAP   = 0;
  localparam int M_STALL = 1;
  localparam int M_BUB   = 2;
  localparam int M_FLUSH = 3;

  typedef struct packed {
    logic        valid;
    logic        load;
    logic [15:0] ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ex_t;

  logic clk;
  logic rst_n;

  decode_stage_pipe_if #(.XLEN(32), .CTRLW(16)) bus ();

  decode_stage_pipe #(.XLEN(32), .NREG(32), .CTRLW(16)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  ex_t         sb_q[$];
  ex_t         last;
  logic [15:0] exp_bub;
  logic [31:0] mdl_rf [32];

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic valid, input logic load,
                       input logic [15:0] ctrl, input logic [31:0] pc);
    bus.instr_d    = instr;
    bus.valid_d    = valid;
    bus.load_d     = load;
    bus.ctrl_d     = ctrl;
    bus.pc_d       = pc;
    bus.pc_plus4_d = pc + 32'd4;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    bus.regwrite_w = en;
    bus.rd_w       = rd;
    bus.result_w   = data;
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.regwrite_w && bus.rd_w == idx) return bus.result_w;
    return mdl_rf[idx];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".valid_e"}, 32'(bus.valid_e), 32'd0);
    check({tag, ".load_e"}, 32'(bus.load_e), 32'd0);
    check({tag, ".ctrl_e"}, 32'(bus.ctrl_e), 32'd0);
    check({tag, ".rd1_e"}, bus.rd1_e, 32'd0);
    check({tag, ".rd2_e"}, bus.rd2_e, 32'd0);
    check({tag, ".imm_e"}, bus.imm_e, 32'd0);
    check({tag, ".rs1_e"}, 32'(bus.rs1_e), 32'd0);
    check({tag, ".rs2_e"}, 32'(bus.rs2_e), 32'd0);
    check({tag, ".rd_e"}, 32'(bus.rd_e), 32'd0);
    check({tag, ".pc_e"}, bus.pc_e, 32'd0);
    check({tag, ".pc_plus4_e"}, bus.pc_plus4_e, 32'd0);
    check({tag, ".instr_e"}, bus.instr_e, 32'd0);
    check({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'd0);
  endtask

  // One clock: check stall_d, push the expected EX contents, clock, pop and compare.
  task automatic step(input string tag, input int mode, input logic [31:0] imm_x);
    ex_t dec;
    ex_t e;
    #1;
    check({tag, ".stall_d"}, 32'(bus.stall_d),
          (mode == M_STALL || mode == M_BUB) ? 32'd1 : 32'd0);
    dec.valid = bus.valid_d;
    dec.load  = bus.valid_d & bus.load_d;
    dec.ctrl  = bus.valid_d ? bus.ctrl_d : 16'd0;
    dec.rs1   = bus.instr_d[19:15];
    dec.rs2   = bus.instr_d[24:20];
    dec.rd    = bus.instr_d[11:7];
    dec.rd1   = mdl_read(dec.rs1);
    dec.rd2   = mdl_read(dec.rs2);
    dec.imm   = imm_x;
    dec.pc    = bus.pc_d;
    dec.pc4   = bus.pc_plus4_d;
    dec.instr = bus.instr_d;
    e = dec;
    case (mode)
      M_STALL: e = last;
      M_BUB: begin
        e = last;
        e.valid = 1'b0; e.load = 1'b0; e.ctrl = 16'd0;
        if (exp_bub != 16'hFFFF) exp_bub = exp_bub + 16'd1;
      end
      M_FLUSH: begin
        e.valid = 1'b0; e.load = 1'b0; e.ctrl = 16'd0;
      end
      default: e = dec;
    endcase
    sb_q.push_back(e);
    if (bus.regwrite_w && bus.rd_w != 5'd0) mdl_rf[bus.rd_w] = bus.result_w;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".valid_e"}, 32'(bus.valid_e), 32'(e.valid));
    check({tag, ".load_e"}, 32'(bus.load_e), 32'(e.load));
    check({tag, ".ctrl_e"}, 32'(bus.ctrl_e), 32'(e.ctrl));
    check({tag, ".rd1_e"}, bus.rd1_e, e.rd1);
    check({tag, ".rd2_e"}, bus.rd2_e, e.rd2);
    check({tag, ".imm_e"}, bus.imm_e, e.imm);
    check({tag, ".rs1_e"}, 32'(bus.rs1_e), 32'(e.rs1));
    check({tag, ".rs2_e"}, 32'(bus.rs2_e), 32'(e.rs2));
    check({tag, ".rd_e"}, 32'(bus.rd_e), 32'(e.rd));
    check({tag, ".pc_e"}, bus.pc_e, e.pc);
    check({tag, ".pc_plus4_e"}, bus.pc_plus4_e, e.pc4);
    check({tag, ".instr_e"}, bus.instr_e, e.instr);
    check({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(exp_bub));
    last = e;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl_rf[i] = 32'd0;
    last    = '0;
    exp_bub = 16'd0;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    bus.flush_e   = 1'b0;
    bus.stall_ext = 1'b0;
    clear_model();

    // Reset must clear outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    @(posedge clk); #1;
    rst_n = 1'b1;

    drive(32'd0, 1'b0, 1'b0, 16'd0, 32'd0);
    wb(1'b1, 5'd5, 32'h10);
    step("wr_x5", M_CAP, 32'd0);

    drive(32'h00428313, 1'b1, 1'b0, 16'h1234, 32'h1000);
    wb(1'b1, 5'd1, 32'h100);
    step("addi", M_CAP, 32'd4);

    drive(r_add(5'd9, 5'd3, 5'd1), 1'b1, 1'b0, 16'h0011, 32'h1004);
    wb(1'b1, 5'd3, 32'hDEADBEEF);
    step("bypass", M_CAP, 32'd0);

    wb(1'b0, 5'd0, 32'd0);
    drive(i_type(12'd8, 5'd1, 3'd2, 5'd7, 7'h03), 1'b1, 1'b1, 16'h00A5, 32'h1008);
    step("lw_x7", M_CAP, 32'd8);

    drive(r_add(5'd8, 5'd7, 5'd1), 1'b1, 1'b0, 16'h0022, 32'h100C);
    wb(1'b1, 5'd7, 32'h77);
    step("load_use", M_BUB, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    step("after_bubble", M_CAP, 32'd0);

    drive(i_type(12'd0, 5'd0, 3'd2, 5'd10, 7'h03), 1'b1, 1'b1, 16'h0033, 32'h1010);
    step("lw_x10", M_CAP, 32'd0);
    drive(r_add(5'd11, 5'd1, 5'd10), 1'b1, 1'b0, 16'h0044, 32'h1014);
    step("rs2_hazard", M_BUB, 32'd0);
    step("rs2_resume", M_CAP, 32'd0);

    drive(i_type(12'd4, 5'd0, 3'd2, 5'd12, 7'h03), 1'b1, 1'b1, 16'h0055, 32'h1018);
    step("lw_x12", M_CAP, 32'd4);
    drive(r_add(5'd13, 5'd12, 5'd12), 1'b1, 1'b0, 16'h0066, 32'h101C);
    bus.stall_ext = 1'b1;
    bus.flush_e   = 1'b1;
    step("flush_prio", M_FLUSH, 32'd0);
    bus.stall_ext = 1'b0;
    bus.flush_e   = 1'b0;

    drive(i_type(12'd0, 5'd1, 3'd2, 5'd0, 7'h03), 1'b1, 1'b1, 16'h0077, 32'h1020);
    step("lw_x0", M_CAP, 32'd0);
    drive(r_add(5'd14, 5'd0, 5'd0), 1'b1, 1'b0, 16'h0088, 32'h1024);
    step("rd0_no_haz", M_CAP, 32'd0);
    drive(i_type(12'd0, 5'd1, 3'd2, 5'd15, 7'h03), 1'b1, 1'b1, 16'h0099, 32'h1028);
    step("lw_x15", M_CAP, 32'd0);
    drive(r_add(5'd16, 5'd15, 5'd15), 1'b0, 1'b1, 16'hFFFF, 32'h102C);
    step("invalid_d", M_CAP, 32'd0);

    drive(s_type(12'hFFC, 5'd5, 5'd6), 1'b1, 1'b0, 16'h0101, 32'h1030);
    step("sw_imm", M_CAP, 32'hFFFFFFFC);
    drive(b_type(13'h1FF8, 5'd6, 5'd5), 1'b1, 1'b0, 16'h0202, 32'h1034);
    bus.stall_ext = 1'b1;
    step("stall1", M_STALL, 32'd0);
    step("stall2", M_STALL, 32'd0);
    step("stall3", M_STALL, 32'd0);
    bus.stall_ext = 1'b0;
    step("beq_imm", M_CAP, 32'hFFFFFFF8);

    drive({20'h12345, 5'd17, 7'h37}, 1'b1, 1'b0, 16'h0303, 32'h1038);
    step("lui_imm", M_CAP, 32'h12345000);
    drive(j_type(21'h000800, 5'd1), 1'b1, 1'b0, 16'h0404, 32'h103C);
    step("jal_pos", M_CAP, 32'h00000800);
    drive(j_type(21'h1FFFFC, 5'd2), 1'b1, 1'b0, 16'h0505, 32'h1040);
    step("jal_neg", M_CAP, 32'hFFFFFFFC);
    drive(i_type(12'h800, 5'd1, 3'd0, 5'd3, 7'h67), 1'b1, 1'b0, 16'h0606, 32'h1044);
    step("jalr_imm", M_CAP, 32'hFFFFF800);

    drive(i_type(12'd1, 5'd0, 3'd0, 5'd18, 7'h13), 1'b1, 1'b0, 16'h0707, 32'h1048);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    step("x0_write", M_CAP, 32'd1);
    wb(1'b0, 5'd0, 32'd0);
    step("x0_read", M_CAP, 32'd1);

    drive(32'h00428313, 1'b1, 1'b0, 16'h0808, 32'h104C);
    step("addi_pre_rst", M_CAP, 32'd4);
    drive(r_add(5'd19, 5'd5, 5'd6), 1'b1, 1'b0, 16'h0909, 32'h1050);
    bus.stall_ext = 1'b1;
    #3 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    @(posedge clk); #1;
    check_zero("reset_hold");
    bus.stall_ext = 1'b0;
    rst_n = 1'b1;
    clear_model();

    drive(32'h00428313, 1'b1, 1'b0, 16'h0A0A, 32'h2000);
    step("post_rst", M_CAP, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
